// File: rtl/asrv32_dmem_bus_if_pkg.sv
// Shared types and constants for the data-memory bus interface and the
// bus watchdog that the instruction-fetch interface will also reuse.
package asrv32_dmem_bus_if_pkg;

  // Transfer FSM encoding: IDLE=0, ISSUE=1, WAIT_ACK=2, DONE=3.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } dmem_state_e;

  // Default watchdog limit in cycles; 0 disables the watchdog.
  localparam int unsigned DMEM_TIMEOUT = 255;

  // Loads always fetch the full word; the core picks bytes afterwards.
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // The bus only carries word addresses; byte lanes travel on the select.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Counter width able to hold 0..timeout, never narrower than one bit.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/asrv32_bus_watchdog.sv
// Cycle counter that flags a bus transfer which has been outstanding for
// i_limit cycles. Clear restarts the count, run advances it; a zero limit
// never expires. The expire flag is registered.
module asrv32_bus_watchdog #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Next count: clear wins, otherwise count up while running and hold at
  // the limit so a stuck transfer keeps reporting expiry.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_run) begin
      if (cnt_q != i_limit) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      expire_d = (i_limit != '0) && (cnt_d == i_limit);
    end
  end

  // Counter and expire flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign o_expire = expire_q;

endmodule

// File: rtl/asrv32_dmem_bus_if.sv
// Data-memory bus interface: turns one memory-stage request into a single
// pipelined Wishbone B4 transfer, stalls the core while it is in flight and
// returns the raw read word plus an error/timeout indication.
module asrv32_dmem_bus_if
  import asrv32_dmem_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wmask,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_bus_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_dat
);

  localparam int unsigned      CNT_W = wdog_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  dmem_state_e state_q, state_d;

  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wd_clear;
  logic        wd_run;
  logic        wd_expire;

  // The watchdog restarts on the IDLE->ISSUE transition and only counts
  // while the transfer is outstanding on the bus.
  assign wd_clear = (state_q == ST_IDLE) && i_req_valid;
  assign wd_run   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK);

  asrv32_bus_watchdog #(
    .CNT_W (CNT_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (wd_clear),
    .i_run    (wd_run),
    .i_limit  (LIMIT),
    .o_expire (wd_expire)
  );

  // Next-state and registered-output decode. The bus strobes and the done
  // pulse are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          state_d = ST_ISSUE;
          we_d    = i_req_we;
          adr_d   = word_align(i_req_addr);
          dat_d   = i_req_wdata;
          sel_d   = i_req_we ? i_req_wmask : SEL_WORD;
        end
      end

      ST_ISSUE: begin
        if (wd_expire) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (!i_wb_stall) begin
          // Strobe accepted; a same-cycle response completes at once.
          // Error takes priority over ack and suppresses the read data.
          if (i_wb_err) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (i_wb_ack) begin
            state_d = ST_DONE;
            if (!we_q) begin
              rdata_d = i_wb_dat;
            end
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (wd_expire) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (i_wb_err) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (i_wb_ack) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = i_wb_dat;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cyc_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK);
    stb_d  = (state_d == ST_ISSUE);
    done_d = (state_d == ST_DONE);
  end

  // State, latched request fields and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall is the one combinational output so the core freezes in the very
  // cycle it presents a request.
  assign o_stall   = ((state_q == ST_IDLE) && i_req_valid) ||
                     (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK);
  assign o_done    = done_q;
  assign o_bus_err = err_q;
  assign o_rdata   = rdata_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = sel_q;

endmodule

// File: tb/tb_asrv32_dmem_bus_if.sv
// Scoreboard bench for asrv32_dmem_bus_if: the stimulus pushes the expected
// completion (read word, error flag, completion cycle) of each request and a
// monitor pops and compares it whenever o_done pulses.
module tb_asrv32_dmem_bus_if;

  localparam int unsigned TO = 6;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wmask;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_bus_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic        i_wb_stall;
  logic [31:0] i_wb_dat;

  logic        sl_ack;
  logic        late_ack;
  assign i_wb_ack = sl_ack | late_ack;

  asrv32_dmem_bus_if #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_wmask (i_req_wmask),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_bus_err   (o_bus_err),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_adr    (o_wb_adr),
    .o_wb_dat    (o_wb_dat),
    .o_wb_sel    (o_wb_sel),
    .i_wb_ack    (i_wb_ack),
    .i_wb_err    (i_wb_err),
    .i_wb_stall  (i_wb_stall),
    .i_wb_dat    (i_wb_dat)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_tot   = 0;
  int   cyc_cnt = 0;

  // Slave behaviour knobs, written only by the stimulus process.
  int          cfg_stall = 0;
  int          cfg_delay = 0;
  logic        cfg_ack   = 1'b1;
  logic        cfg_err   = 1'b0;
  logic        cfg_never = 1'b0;
  logic [31:0] cfg_dat   = 32'h0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic push(input string nm, input logic [31:0] rd, input logic er, input int cy);
    exp_t e;
    e.name = nm; e.rdata = rd; e.err = er; e.cyc = cy;
    sb.push_back(e);
  endtask

  task automatic cfg(input int st, input int dl, input logic ak, input logic er,
                     input logic nv, input logic [31:0] dt);
    cfg_stall = st; cfg_delay = dl; cfg_ack = ak; cfg_err = er; cfg_never = nv; cfg_dat = dt;
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_wmask = m;
  endtask

  // Wishbone slave model: stalls the strobe cfg_stall cycles, then answers
  // cfg_delay cycles after acceptance (0 = in the accept cycle).
  initial begin : slave
    int stalled;
    int delay_left;
    bit active;
    stalled = 0; delay_left = 0; active = 0;
    sl_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_dat = 32'h0;
    forever begin
      @(posedge i_clk);
      #1;
      sl_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_dat = cfg_dat;
      if (!o_wb_cyc) begin
        active = 0; stalled = 0;
      end else if (o_wb_stb) begin
        if (stalled < cfg_stall) begin
          i_wb_stall = 1'b1; stalled++;
        end else begin
          active = 1; delay_left = cfg_delay;
        end
      end
      if (active && !i_wb_stall) begin
        if (delay_left == 0) begin
          if (!cfg_never) begin
            sl_ack = cfg_ack; i_wb_err = cfg_err;
          end
          active = 0;
        end else begin
          delay_left--;
        end
      end
    end
  end

  // Monitor: every o_done must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(o_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdata"}, o_rdata, e.rdata);
        chk({e.name, "_err"}, 32'(o_bus_err), 32'(e.err));
        chk({e.name, "_cycle"}, cyc_cnt, e.cyc);
      end
    end
  end

  initial begin : stim
    int c;
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0;
    i_req_addr = 32'h0; i_req_wdata = 32'h0; i_req_wmask = 4'h0; late_ack = 1'b0;

    // Reset state
    repeat (2) nxt();
    smp();
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_done",  32'(o_done), 32'd0);
    chk("rst_err",   32'(o_bus_err), 32'd0);
    chk("rst_cyc",   32'(o_wb_cyc), 32'd0);
    chk("rst_stb",   32'(o_wb_stb), 32'd0);
    chk("rst_adr",   o_wb_adr, 32'h0);
    chk("rst_sel",   32'(o_wb_sel), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);

    // Zero-wait load presented in the cycle reset is released
    nxt();
    i_rst_n = 1'b1;
    c = cyc_cnt;
    cfg(0, 0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    req(1'b0, 32'h0000_1006, 32'h5555_5555, 4'h3);
    push("load0", 32'hDEAD_BEEF, 1'b0, c + 2);
    smp();
    chk("load0_stall_c0", 32'(o_stall), 32'd1);
    nxt();
    i_req_valid = 1'b0;
    smp();
    chk("load0_cyc", 32'(o_wb_cyc), 32'd1);
    chk("load0_stb", 32'(o_wb_stb), 32'd1);
    chk("load0_we",  32'(o_wb_we), 32'd0);
    chk("load0_adr", o_wb_adr, 32'h0000_1004);
    chk("load0_sel", 32'(o_wb_sel), 32'hF);
    chk("load0_stall_c1", 32'(o_stall), 32'd1);
    nxt();
    smp();
    chk("load0_stall_c2", 32'(o_stall), 32'd0);
    chk("load0_cyc_c2", 32'(o_wb_cyc), 32'd0);
    nxt();

    // Store, slave stalls 3 cycles then acks one cycle after acceptance
    c = cyc_cnt;
    cfg(3, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000);
    req(1'b1, 32'h2000_0013, 32'hABCD_0000, 4'hC);
    push("store_stall", 32'hDEAD_BEEF, 1'b0, c + 6);
    nxt();
    i_req_valid = 1'b0;
    smp();
    chk("store_we",  32'(o_wb_we), 32'd1);
    chk("store_sel", 32'(o_wb_sel), 32'hC);
    chk("store_dat", o_wb_dat, 32'hABCD_0000);
    chk("store_adr", o_wb_adr, 32'h2000_0010);
    repeat (3) nxt();
    smp();
    chk("store_stb_accept", 32'(o_wb_stb), 32'd1);
    nxt();
    smp();
    chk("store_wait_stb", 32'(o_wb_stb), 32'd0);
    chk("store_wait_cyc", 32'(o_wb_cyc), 32'd1);
    chk("store_wait_stall", 32'(o_stall), 32'd1);
    repeat (2) nxt();

    // ack and err together in WAIT_ACK: error wins, read word untouched
    c = cyc_cnt;
    cfg(0, 1, 1'b1, 1'b1, 1'b0, 32'h1234_5678);
    req(1'b0, 32'h3000_0008, 32'h0, 4'h0);
    push("ack_err", 32'hDEAD_BEEF, 1'b1, c + 3);
    nxt();
    i_req_valid = 1'b0;
    nxt();
    smp();
    chk("ack_err_wait_cyc", 32'(o_wb_cyc), 32'd1);
    repeat (2) nxt();

    // Load with one stall cycle and two wait cycles
    c = cyc_cnt;
    cfg(1, 2, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    req(1'b0, 32'h0000_0100, 32'h0, 4'h1);
    push("load_slow", 32'h0BAD_F00D, 1'b0, c + 5);
    nxt();
    i_req_valid = 1'b0;
    repeat (5) nxt();

    // Watchdog timeout: slave never answers
    c = cyc_cnt;
    cfg(0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    req(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    push("timeout", 32'h0BAD_F00D, 1'b1, c + TO + 2);
    nxt();
    i_req_valid = 1'b0;
    repeat (TO) nxt();
    smp();
    chk("timeout_cyc_before", 32'(o_wb_cyc), 32'd1);
    nxt();
    late_ack = 1'b1;
    smp();
    chk("timeout_cyc_dropped", 32'(o_wb_cyc), 32'd0);
    nxt();
    smp();
    chk("late_ack_stall", 32'(o_stall), 32'd0);
    chk("late_ack_stb", 32'(o_wb_stb), 32'd0);
    nxt();
    late_ack = 1'b0;
    smp();
    chk("late_ack_cyc", 32'(o_wb_cyc), 32'd0);
    chk("late_ack_rdata", o_rdata, 32'h0BAD_F00D);

    // Reset asserted while waiting for ack
    nxt();
    cfg(0, 0, 1'b1, 1'b0, 1'b1, 32'h0);
    req(1'b0, 32'h6000_0000, 32'h0, 4'h0);
    nxt();
    i_req_valid = 1'b0;
    nxt();
    smp();
    chk("rst_mid_cyc_before", 32'(o_wb_cyc), 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc",   32'(o_wb_cyc), 32'd0);
    chk("rst_mid_stb",   32'(o_wb_stb), 32'd0);
    chk("rst_mid_done",  32'(o_done), 32'd0);
    chk("rst_mid_stall", 32'(o_stall), 32'd0);
    chk("rst_mid_rdata", o_rdata, 32'h0);
    nxt();
    i_rst_n = 1'b1;
    nxt();
    c = cyc_cnt;
    cfg(0, 0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
    push("load_after_rst", 32'hCAFE_F00D, 1'b0, c + 2);
    nxt();
    i_req_valid = 1'b0;
    repeat (2) nxt();

    // Back-to-back with i_req_valid held high: load then store
    c = cyc_cnt;
    cfg(0, 0, 1'b1, 1'b0, 1'b0, 32'h1111_2222);
    req(1'b0, 32'h5000_0004, 32'h0, 4'h0);
    push("b2b_load", 32'h1111_2222, 1'b0, c + 2);
    nxt();
    req(1'b1, 32'h5000_0008, 32'h0000_BEEF, 4'h3);
    push("b2b_store", 32'h1111_2222, 1'b0, c + 5);
    nxt();
    smp();
    chk("b2b_done_stall", 32'(o_stall), 32'd0);
    nxt();
    smp();
    chk("b2b_idle_stall", 32'(o_stall), 32'd1);
    chk("b2b_idle_stb", 32'(o_wb_stb), 32'd0);
    nxt();
    i_req_valid = 1'b0;
    smp();
    chk("b2b_stb", 32'(o_wb_stb), 32'd1);
    chk("b2b_we",  32'(o_wb_we), 32'd1);
    chk("b2b_sel", 32'(o_wb_sel), 32'h3);
    chk("b2b_adr", o_wb_adr, 32'h5000_0008);
    chk("b2b_dat", o_wb_dat, 32'h0000_BEEF);
    repeat (4) nxt();

    smp();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
